tdm_arbiter: RTL and testbench
==============================

TDM_ARBITER -- requirements
Module: tdm_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each channel and of the output.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port a_data, input, WIDTH, channel A word.
REQ-005 Port a_valid, input, 1, channel A word present.
REQ-006 Port a_ready, output, 1, channel A buffer can accept.
REQ-007 Ports b_data / b_valid / b_ready, same as REQ-004 to REQ-006, for channel B.
REQ-008 Port y_data, output, WIDTH, selected word.
REQ-009 Port y_valid, output, 1, y_data holds a word.
REQ-010 Port y_ready, input, 1, consumer accepts y_data.
REQ-011 Port s, output, 1, source of the word in the output register (0 = A, 1 = B); drives a downstream 2:1 mux select.
REQ-012 Port tx_count, output, 16, number of words delivered.

Function
REQ-013 Handshakes: an input transfer occurs on a rising edge with x_valid=1 and x_ready=1. An output transfer occurs on a rising edge with y_valid=1 and y_ready=1.
REQ-014 Each channel has a one-entry holding buffer with a full flag; x_ready = NOT full, driven from a register with no combinational path from any input.
REQ-015 An input transfer captures x_data into the buffer and sets full.
REQ-016 The output register is "free" when y_valid=0, or when an output transfer occurs on the same edge.
REQ-017 On an edge where the output register is free and at least one buffer is full, the block:
- loads one buffer into y_data;
- sets y_valid=1;
- sets s to the granted channel;
- clears that buffer's full flag.
REQ-018 Grant rule:
- only A full -> A;
- only B full -> B;
- both full -> the channel not granted last (round-robin pointer last_grant).
REQ-019 last_grant updates to the granted channel on every load.
REQ-020 Output FSM states:
- EMPTY (y_valid=0);
- HOLD (y_valid=1).
REQ-021 FSM transitions:
- EMPTY->HOLD on load;
- HOLD->HOLD on a transfer with a load, or while stalled;
- HOLD->EMPTY on a transfer with no buffer full.
REQ-022 While y_valid=1 and y_ready=0, y_data and s are held stable.
REQ-023 Latency: a word captured at edge k appears with y_valid=1 after edge k+1 if the output register is free at k+1.
REQ-024 Throughput:
- per channel, at most one word every 2 cycles;
- aggregate, one word per cycle with both channels active and y_ready=1.
REQ-025 An input transfer into a buffer and a load from that same buffer cannot coincide, because ready is low while full. Loading from A while capturing into B on the same edge is legal.
REQ-026 tx_count increments by 1 on each output transfer and wraps from 0xFFFF to 0x0000.
REQ-027 Words are never dropped or duplicated; per-channel order is preserved.

Reset
REQ-028 While rst=1, the following outputs are forced asynchronously, including mid-transfer:
- y_valid=0;
- y_data=0;
- s=0;
- tx_count=0;
- a_ready=1 and b_ready=1.
REQ-029 While rst=1, internal state is forced asynchronously: both full flags cleared, FSM in EMPTY, last_grant=1 (B), so A wins the first tie.
REQ-030 Words held in buffers or the output register at reset assertion are discarded. Operation resumes on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package tdm_pkg holds:
- the WIDTH default;
- the channel encoding CH_A=0, CH_B=1;
- the FSM state encoding EMPTY/HOLD.
REQ-032 One sub-module, hold_buffer (data register plus full flag plus ready), is instantiated twice, once for A and once for B.

Verification
REQ-033 Reset: assert rst mid-HOLD with y_data=0x5A -> y_valid=0, s=0, tx_count=0, a_ready=b_ready=1 immediately, without waiting for a clock.
REQ-034 Single A word: a_data=0x3C, one transfer at edge k, y_ready=1 -> y_valid=1, y_data=0x3C, s=0 after edge k+1; tx_count=1 after edge k+2.
REQ-035 Tie: A=0x11 and B=0x22 captured on the same edge after reset -> outputs are 0x11 (s=0), then 0x22 (s=1) on consecutive cycles.
REQ-036 Stall: y_ready=0 for 5 cycles with 0xAA held -> y_data=0xAA and s constant; a_ready=0 once the A buffer refills; no loss after y_ready returns to 1.
REQ-037 Streaming: both channels valid continuously for 20 cycles, y_ready=1 -> strict A/B alternation in s, one word per cycle, tx_count=20.
REQ-038 Wrap: preload tx_count near 0xFFFF via 65536 transfers -> reads 0x0000 after the 65536th transfer.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM arbiter.
// Holds the default data width, the channel encoding used on the s output
// and the output-register FSM state encoding, plus the grant helper.
package tdm_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // Channel encoding; also the value driven on s for the downstream mux.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Output register FSM: EMPTY means y_valid=0, HOLD means y_valid=1.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Grant: a lone full buffer wins; on a tie the channel not granted last wins.
  function automatic logic pick_channel(input logic a_full,
                                        input logic b_full,
                                        input logic last_grant);
    logic g;
    if (a_full && b_full) begin
      g = ~last_grant;
    end else if (b_full) begin
      g = CH_B;
    end else begin
      g = CH_A;
    end
    return g;
  endfunction

endpackage

// File: rtl/tdm_arbiter_hold_buffer.sv
// hold_buffer: one-entry skid slot (data register + full flag) for one input channel.
// Latency: word visible on out_data/full the edge after capture; cleared by take.
// Backpressure: in_ready is a register (NOT full), no combinational input path.
// Ports: in_data/in_valid/in_ready input handshake; take clears the slot;
//        out_data/full expose the stored word to the arbiter.
module hold_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  // in_ready is kept as its own flop, always the complement of full, so the
  // upstream sees a clean registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      in_ready <= 1'b1;
      out_data <= '0;
    end else if (in_valid && in_ready) begin
      // Capture and take never coincide: take needs full, capture needs !full.
      out_data <= in_data;
      full     <= 1'b1;
      in_ready <= 1'b0;
    end else if (take) begin
      full     <= 1'b0;
      in_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/tdm_arbiter.sv
// tdm_arbiter: round-robin merge of two valid/ready channels into one output register.
// Latency: word captured at edge k is on y_data after edge k+1 when the output is free.
// Backpressure: y_ready=0 holds y_data/s; buffers fill and drop a_ready/b_ready.
// Ports: clk, rst (async, active-high); a_*/b_* input channels; y_* output
//        channel; s = source of y_data (0=A, 1=B); tx_count = words delivered.
module tdm_arbiter
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s,
  output logic [15:0]      tx_count
);

  logic [WIDTH-1:0] a_buf;
  logic [WIDTH-1:0] b_buf;
  logic             a_full;
  logic             b_full;
  logic [0:0]       state;
  logic             last_grant;
  logic             y_xfer;
  logic             out_free;
  logic             load;
  logic             grant;

  hold_buffer #(.WIDTH(WIDTH)) u_buf_a (
    .clk      (clk),
    .rst      (rst),
    .in_data  (a_data),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .take     (load && (grant == CH_A)),
    .out_data (a_buf),
    .full     (a_full)
  );

  hold_buffer #(.WIDTH(WIDTH)) u_buf_b (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_data),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .take     (load && (grant == CH_B)),
    .out_data (b_buf),
    .full     (b_full)
  );

  assign y_valid  = (state == ST_HOLD);
  assign y_xfer   = y_valid && y_ready;
  // The output register can take a new word if empty or being drained this edge.
  assign out_free = !y_valid || y_ready;
  assign load     = out_free && (a_full || b_full);
  assign grant    = pick_channel(a_full, b_full, last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      y_data     <= '0;
      s          <= CH_A;
      last_grant <= CH_B;  // so A wins the first tie after reset
      tx_count   <= 16'd0;
    end else begin
      if (y_xfer) begin
        tx_count <= tx_count + 16'd1;  // wraps naturally at 16 bits
      end
      if (load) begin
        y_data     <= (grant == CH_B) ? b_buf : a_buf;
        s          <= grant;
        last_grant <= grant;
      end
      case (state)
        ST_EMPTY: if (load) state <= ST_HOLD;
        ST_HOLD:  if (y_xfer && !load) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_arbiter.sv
module tb_tdm_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] y_data;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic       s;
  logic [15:0] tx_count;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  tdm_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .s(s), .tx_count(tx_count)
  );

  // Reference model: each channel is a queue of at most one word waiting;
  // the output slot holds one word and its source channel.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         m_vld;
  logic [7:0] m_dat;
  bit         m_src;
  bit         m_last;
  logic [15:0] m_cnt;
  int         m_ntx;
  bit         a_took;
  bit         b_took;

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_vld = 0; m_dat = 8'h00; m_src = 0; m_last = 1; m_cnt = 16'h0; m_ntx = 0;
    a_took = 0; b_took = 0;
  endtask

  // Advance one rising edge and apply the rules to the model with the inputs
  // that were present before the edge; returns 1 ns after the edge.
  task automatic tick();
    bit a_cap, b_cap, xfer, free, g;
    @(posedge clk);
    a_cap = a_valid && (qa.size() == 0);
    b_cap = b_valid && (qb.size() == 0);
    xfer  = m_vld && y_ready;
    free  = !m_vld || y_ready;
    if (xfer) begin m_cnt = m_cnt + 16'd1; m_ntx++; end
    if (free && (qa.size() != 0 || qb.size() != 0)) begin
      if (qa.size() != 0 && qb.size() != 0) g = !m_last;
      else g = (qb.size() != 0);
      m_dat = g ? qb.pop_front() : qa.pop_front();
      m_src = g; m_last = g; m_vld = 1;
    end else if (xfer) begin
      m_vld = 0;
    end
    if (a_cap) qa.push_back(a_data);
    if (b_cap) qb.push_back(b_data);
    a_took = a_cap; b_took = b_cap;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; y_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    a_data = 8'h5A; a_valid = 1; y_ready = 0;
    tick();
    a_valid = 0;
    tick();
    tick();
    ntotal++;
    if ({y_valid, y_data} !== {1'b1, 8'h5A}) $display("FAIL reset_setup got v=%b d=%h need v=1 d=5a", y_valid, y_data);
    else npass++;
    // Assert reset between edges; outputs must respond without a clock edge.
    @(posedge clk); #2 rst = 1'b1; #1;
    ntotal++;
    if ({y_valid, y_data, s, tx_count, a_ready, b_ready} !== {1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 1'b1})
      $display("FAIL reset_async got v=%b d=%h s=%b cnt=%h ar=%b br=%b need 0 00 0 0000 1 1",
               y_valid, y_data, s, tx_count, a_ready, b_ready);
    else npass++;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_a();
    do_reset();
    y_ready = 1; a_data = 8'h3C; a_valid = 1;
    tick();
    a_valid = 0;
    ntotal++;
    if ({a_ready, y_valid} !== 2'b00) $display("FAIL single_capture got ar=%b v=%b need 0 0", a_ready, y_valid);
    else npass++;
    tick();
    ntotal++;
    if ({y_valid, y_data, s, tx_count} !== {1'b1, 8'h3C, 1'b0, 16'd0})
      $display("FAIL single_out got v=%b d=%h s=%b cnt=%0d need 1 3c 0 0", y_valid, y_data, s, tx_count);
    else npass++;
    tick();
    ntotal++;
    if ({y_valid, tx_count, a_ready} !== {1'b0, 16'd1, 1'b1})
      $display("FAIL single_done got v=%b cnt=%0d ar=%b need 0 1 1", y_valid, tx_count, a_ready);
    else npass++;
  endtask

  task automatic test_tie();
    do_reset();
    y_ready = 1; a_data = 8'h11; b_data = 8'h22; a_valid = 1; b_valid = 1;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    ntotal++;
    if ({y_valid, y_data, s} !== {1'b1, 8'h11, 1'b0}) $display("FAIL tie_first got v=%b d=%h s=%b need 1 11 0", y_valid, y_data, s);
    else npass++;
    tick();
    ntotal++;
    if ({y_valid, y_data, s} !== {1'b1, 8'h22, 1'b1}) $display("FAIL tie_second got v=%b d=%h s=%b need 1 22 1", y_valid, y_data, s);
    else npass++;
    tick();
    ntotal++;
    if ({y_valid, tx_count} !== {1'b0, 16'd2}) $display("FAIL tie_done got v=%b cnt=%0d need 0 2", y_valid, tx_count);
    else npass++;
  endtask

  task automatic test_stall();
    do_reset();
    y_ready = 0; a_data = 8'hAA; a_valid = 1;
    tick();
    a_data = 8'hBB;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) a_valid = 0;
      ntotal++;
      if ({y_valid, y_data, s} !== {1'b1, 8'hAA, 1'b0})
        $display("FAIL stall_hold[%0d] got v=%b d=%h s=%b need 1 aa 0", i, y_valid, y_data, s);
      else npass++;
      if (i >= 1) begin
        ntotal++;
        if (a_ready !== 1'b0) $display("FAIL stall_aready[%0d] got %b need 0", i, a_ready);
        else npass++;
      end
    end
    y_ready = 1;
    tick();
    ntotal++;
    if ({y_valid, y_data, s} !== {1'b1, 8'hBB, 1'b0}) $display("FAIL stall_next got v=%b d=%h s=%b need 1 bb 0", y_valid, y_data, s);
    else npass++;
    tick();
    ntotal++;
    if ({y_valid, tx_count} !== {1'b0, 16'd2}) $display("FAIL stall_done got v=%b cnt=%0d need 0 2", y_valid, tx_count);
    else npass++;
  endtask

  task automatic test_stream();
    bit prev_v;
    bit prev_s;
    int guard;
    do_reset();
    y_ready = 1; a_valid = 1; b_valid = 1;
    a_data = 8'($urandom); b_data = 8'($urandom);
    prev_v = 0; prev_s = 0;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (a_took) a_data = 8'($urandom);
      if (b_took) b_data = 8'($urandom);
      if (e == 20) begin a_valid = 0; b_valid = 0; end
      ntotal++;
      if ({y_valid, s, y_data} !== {m_vld, m_src, m_dat})
        $display("FAIL stream_model[%0d] got v=%b s=%b d=%h need v=%b s=%b d=%h", e, y_valid, s, y_data, m_vld, m_src, m_dat);
      else npass++;
      if (e >= 2 && e <= 21) begin
        ntotal++;
        if (y_valid !== 1'b1 || (prev_v && s === prev_s))
          $display("FAIL stream_alt[%0d] got v=%b s=%b prev_s=%b need v=1 alternating s", e, y_valid, s, prev_s);
        else npass++;
      end
      prev_v = y_valid; prev_s = s;
    end
    guard = 0;
    while (y_valid && guard < 10) begin tick(); guard++; end
    ntotal++;
    if ({y_valid, tx_count} !== {1'b0, 16'd20}) $display("FAIL stream_count got v=%b cnt=%0d need 0 20", y_valid, tx_count);
    else npass++;
  endtask

  task automatic test_random();
    int guard;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!a_valid || a_took) a_data = 8'($urandom);
      if (!b_valid || b_took) b_data = 8'($urandom);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      y_ready = ($urandom_range(0, 3) != 0);
      tick();
      ntotal++;
      if ({y_valid, s, y_data, a_ready, b_ready, tx_count} !==
          {m_vld, m_src, m_dat, qa.size() == 0, qb.size() == 0, m_cnt})
        $display("FAIL random[%0d] got v=%b s=%b d=%h ar=%b br=%b cnt=%0d need v=%b s=%b d=%h ar=%b br=%b cnt=%0d",
                 c, y_valid, s, y_data, a_ready, b_ready, tx_count,
                 m_vld, m_src, m_dat, qa.size() == 0, qb.size() == 0, m_cnt);
      else npass++;
    end
    a_valid = 0; b_valid = 0; y_ready = 1;
    guard = 0;
    while ((m_vld || qa.size() != 0 || qb.size() != 0) && guard < 10) begin tick(); guard++; end
    ntotal++;
    if ({y_valid, tx_count} !== {1'b0, 16'(m_ntx)})
      $display("FAIL random_drain got v=%b cnt=%0d need 0 %0d", y_valid, tx_count, m_ntx);
    else npass++;
  endtask

  task automatic test_wrap();
    int guard;
    do_reset();
    y_ready = 1; a_valid = 1; b_valid = 1;
    guard = 0;
    while (m_ntx < 65535 && guard < 70000) begin
      tick(); guard++;
      if (a_took) a_data = a_data + 8'd1;
      if (b_took) b_data = b_data + 8'd3;
    end
    ntotal++;
    if (m_ntx != 65535 || tx_count !== 16'hFFFF)
      $display("FAIL wrap_ffff got cnt=%h after %0d transfers need ffff after 65535", tx_count, m_ntx);
    else npass++;
    guard = 0;
    while (m_ntx < 65536 && guard < 4) begin tick(); guard++; end
    ntotal++;
    if (m_ntx != 65536 || tx_count !== 16'h0000)
      $display("FAIL wrap_zero got cnt=%h after %0d transfers need 0000 after 65536", tx_count, m_ntx);
    else npass++;
    a_valid = 0; b_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_a();
    test_tie();
    test_stall();
    test_stream();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
